// File: rtl/prior_enc_pkg.sv
// Shared definitions for the prior_enc_rr priority encoder/arbiter.
// Holds the mode encoding and the wrap-around index arithmetic used by the core and the top level.
package prior_enc_pkg;

    localparam logic PE_MODE_FIXED = 1'b0;
    localparam logic PE_MODE_RR    = 1'b1;

    // Returns (idx - step) mod n for idx < n and step <= n.
    // Wraps with an explicit compare, so it stays correct when n is not a power of two.
    function automatic int unsigned pe_wrap_dec(input int unsigned idx,
                                                input int unsigned step,
                                                input int unsigned n);
        return (idx >= step) ? (idx - step) : (idx + n - step);
    endfunction

endpackage

// File: rtl/prior_enc_core.sv
// Combinational selector. It rotates req so that the search start sits in the MSB position,
// scans for the highest set bit, and maps the hit back to a requester index.
module prior_enc_core
    import prior_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [W-1:0] base;
    logic [N-1:0] rot;

    // Fixed mode is round-robin with the search permanently anchored at N-1.
    assign base = (mode == PE_MODE_RR) ? start : W'(N - 1);

    always_comb begin
        int hit;
        // NOTE: every output of this block is given a default first, so no path leaves a value unassigned and no latch is inferred.
        rot   = '0;
        valid = 1'b0;
        idx   = '0;
        hit   = -1;
        for (int k = 0; k < N; k++) begin
            rot[N-1-k] = req[pe_wrap_dec(int'(base), k, N)];
        end
        for (int k = 0; k < N; k++) begin
            if (hit < 0 && rot[N-1-k]) begin
                hit = k;
            end
        end
        if (hit >= 0) begin
            valid = 1'b1;
            idx   = W'(pe_wrap_dec(int'(base), hit, N));
        end
    end

endmodule

// File: rtl/prior_enc_rr.sv
// Registered priority encoder/arbiter with fixed-priority or round-robin selection.
// Output uses a valid/ready handshake; a presented grant is held until the consumer accepts it.
module prior_enc_rr
    import prior_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] grant
);

    logic [W-1:0] ptr;
    logic         core_valid;
    logic [W-1:0] core_idx;
    logic         load;

    prior_enc_core #(
        .N (N),
        .W (W)
    ) u_core (
        .req   (req),
        .start (ptr),
        .mode  (mode),
        .valid (core_valid),
        .idx   (core_idx)
    );

    // An empty output slot or an accepted output both free the register for a new selection.
    assign load = !out_valid || out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            grant     <= '0;
            ptr       <= W'(N - 1);
        end else if (load) begin
            if (core_valid) begin
                out_valid <= 1'b1;
                out_idx   <= core_idx;
                grant     <= N'(1) << core_idx;
                // The last winner drops to the lowest priority for the next round-robin search.
                if (mode == PE_MODE_RR) begin
                    ptr <= W'(pe_wrap_dec(int'(core_idx), 1, N));
                end
            end else begin
                out_valid <= 1'b0;
                out_idx   <= '0;
                grant     <= '0;
            end
        end
    end

endmodule
